// File: rtl/rf_valid_ckpt_if.sv
// rtl/rf_valid_ckpt_if.sv - dispatch/commit/checkpoint bundle for the register-valid tracker
interface rf_valid_ckpt_if #(
    parameter int AREGS   = 64,
    parameter int NDISP   = 2,
    parameter int NCOMMIT = 2,
    parameter int NCKPT   = 4,
    parameter int IDW     = 5,
    parameter int RW      = 6
);
    localparam int LW = (NDISP > 1) ? $clog2(NDISP) : 1;
    localparam int CW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

    logic [NDISP-1:0]         disp_v;
    logic [NDISP-1:0]         disp_rfw;
    logic [NDISP*RW-1:0]      disp_tgt;
    logic [NDISP*IDW-1:0]     disp_id;
    logic                     ckpt_req;
    logic [LW-1:0]            ckpt_lane;
    logic [CW-1:0]            ckpt_ndx;
    logic                     ckpt_full;
    logic                     ckpt_free;
    logic                     restore;
    logic [CW-1:0]            restore_ndx;
    logic [NCOMMIT-1:0]       commit_v;
    logic [NCOMMIT*RW-1:0]    commit_tgt;
    logic [NCOMMIT*IDW-1:0]   commit_id;
    logic [AREGS-1:0]         rf_v;
    logic [AREGS*IDW-1:0]     rf_source;
    logic                     ckpt_err;

    modport master (
        output disp_v, disp_rfw, disp_tgt, disp_id, ckpt_req, ckpt_lane, ckpt_free,
               restore, restore_ndx, commit_v, commit_tgt, commit_id,
        input  ckpt_ndx, ckpt_full, rf_v, rf_source, ckpt_err
    );

    modport slave (
        input  disp_v, disp_rfw, disp_tgt, disp_id, ckpt_req, ckpt_lane, ckpt_free,
               restore, restore_ndx, commit_v, commit_tgt, commit_id,
        output ckpt_ndx, ckpt_full, rf_v, rf_source, ckpt_err
    );
endinterface

// File: rtl/rf_valid_ckpt.sv
// rtl/rf_valid_ckpt.sv - register valid/source tracker with a ring of recovery snapshots
module rf_valid_ckpt #(
    parameter int AREGS   = 64,
    parameter int NDISP   = 2,
    parameter int NCOMMIT = 2,
    parameter int NCKPT   = 4,
    parameter int IDW     = 5,
    parameter int RW      = 6
) (
    input  logic           clk,
    input  logic           rst,
    rf_valid_ckpt_if.slave bus_io
);
    localparam int LW = (NDISP > 1) ? $clog2(NDISP) : 1;
    localparam int CW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

    typedef logic [AREGS-1:0]          vvec_t;
    typedef logic [AREGS-1:0][IDW-1:0] svec_t;

    vvec_t              v_q, v_d;
    svec_t              s_q, s_d;
    vvec_t [NCKPT-1:0]  sv_q, sv_d;
    svec_t [NCKPT-1:0]  ss_q, ss_d;
    logic [CW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CW:0]        cnt_q, cnt_d;
    logic               err_q, err_d;

    vvec_t              snap_v;
    svec_t              snap_s;
    logic [RW-1:0]      ctgt, dtgt;
    logic [IDW-1:0]     cid, did;
    logic [CW-1:0]      rpos, kpos;
    logic               full, rvalid, restore_ok, free_ok, alloc;

    always_comb begin
        v_d    = v_q;
        s_d    = s_q;
        sv_d   = sv_q;
        ss_d   = ss_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        snap_v = v_q;
        snap_s = s_q;
        ctgt   = '0;
        cid    = '0;
        dtgt   = '0;
        did    = '0;
        kpos   = '0;

        full       = (cnt_q == (CW+1)'(NCKPT));
        rpos       = bus_io.restore_ndx - head_q;
        rvalid     = ({1'b0, rpos} < cnt_q);
        restore_ok = bus_io.restore && rvalid;
        free_ok    = bus_io.ckpt_free && (cnt_q != '0)
                     && !(bus_io.restore && (!rvalid || rpos == '0));
        alloc      = bus_io.ckpt_req && !bus_io.restore && (!full || free_ok);
        err_d      = (bus_io.ckpt_req && (bus_io.restore || (full && !free_ok)))
                     || (bus_io.ckpt_free && !free_ok)
                     || (bus_io.restore && !rvalid);

        // Commits retire against the live source and, independently, each live slot's own source.
        for (int p = 0; p < NCOMMIT; p++) begin
            ctgt = bus_io.commit_tgt[p*RW +: RW];
            cid  = bus_io.commit_id[p*IDW +: IDW];
            if (bus_io.commit_v[p] && ctgt != '0) begin
                if (s_q[ctgt] == cid) v_d[ctgt] = 1'b1;
                for (int k = 0; k < NCKPT; k++) begin
                    kpos = CW'(k) - head_q;
                    if (({1'b0, kpos} < cnt_q) && ss_q[k][ctgt] == cid) sv_d[k][ctgt] = 1'b1;
                end
            end
        end

        if (bus_io.restore) begin
            if (restore_ok) begin
                v_d = sv_d[bus_io.restore_ndx];
                s_d = ss_q[bus_io.restore_ndx];
            end
        end else begin
            for (int l = 0; l < NDISP; l++) begin
                dtgt = bus_io.disp_tgt[l*RW +: RW];
                did  = bus_io.disp_id[l*IDW +: IDW];
                if (bus_io.disp_v[l] && bus_io.disp_rfw[l] && dtgt != '0) begin
                    v_d[dtgt] = 1'b0;
                    s_d[dtgt] = did;
                end
                if (LW'(l) == bus_io.ckpt_lane) begin
                    snap_v = v_d;
                    snap_s = s_d;
                end
            end
        end

        if (alloc) begin
            sv_d[tail_q] = snap_v;
            ss_d[tail_q] = snap_s;
        end

        head_d = head_q + CW'(free_ok);
        if (restore_ok) begin
            tail_d = bus_io.restore_ndx + CW'(1);
            cnt_d  = {1'b0, rpos} + (CW+1)'(1) - (CW+1)'(free_ok);
        end else begin
            tail_d = tail_q + CW'(alloc);
            cnt_d  = cnt_q + (CW+1)'(alloc) - (CW+1)'(free_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '1;
            s_q    <= '0;
            sv_q   <= '1;
            ss_q   <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            s_q    <= s_d;
            sv_q   <= sv_d;
            ss_q   <= ss_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus_io.rf_v      = v_q;
    assign bus_io.rf_source = s_q;
    assign bus_io.ckpt_ndx  = tail_q;
    assign bus_io.ckpt_full = full;
    assign bus_io.ckpt_err  = err_q;
endmodule

// File: tb/tb_rf_valid_ckpt.sv
// tb/tb_rf_valid_ckpt.sv - scoreboard bench for rf_valid_ckpt against a queue-based reference model
module tb_rf_valid_ckpt;
    localparam int AREGS = 64, NDISP = 2, NCOMMIT = 2, NCKPT = 4, IDW = 5, RW = 6;

    logic clk = 1'b0;
    logic rst;

    rf_valid_ckpt_if #(.AREGS(AREGS), .NDISP(NDISP), .NCOMMIT(NCOMMIT),
                       .NCKPT(NCKPT), .IDW(IDW), .RW(RW)) bus ();
    rf_valid_ckpt #(.AREGS(AREGS), .NDISP(NDISP), .NCOMMIT(NCOMMIT),
                    .NCKPT(NCKPT), .IDW(IDW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .bus_io(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst;
        logic [1:0] dv, drfw;
        logic [1:0][5:0] dtgt;
        logic [1:0][4:0] did;
        logic req, lane, free, restore;
        logic [1:0] rndx;
        logic [1:0] cv;
        logic [1:0][5:0] ctgt;
        logic [1:0][4:0] cid;
    } stim_t;
    typedef struct packed { logic [63:0] v; logic [63:0][4:0] s; } snap_t;
    typedef struct packed { logic [63:0] v; logic [63:0][4:0] s; logic full; logic [1:0] ndx; logic err; } exp_t;

    exp_t  expq[$];
    snap_t ckq[$];
    logic [63:0]      mv = '1;
    logic [63:0][4:0] ms = '0;
    int mhead = 0;
    int errors = 0, checks = 0, ncyc = 0;

    task automatic model_step(input stim_t s, output exp_t e);
        logic [63:0] nv;
        logic [63:0][4:0] ns;
        snap_t sn, t;
        int pos;
        logic er, dofree, doreq;
        er = 1'b0;
        if (s.rst) begin
            mv = '1; ms = '0; ckq.delete(); mhead = 0;
        end else begin
            nv = mv; ns = ms;
            for (int p = 0; p < NCOMMIT; p++)
                if (s.cv[p] && s.ctgt[p] != 0 && ms[s.ctgt[p]] == s.cid[p]) nv[s.ctgt[p]] = 1'b1;
            for (int k = 0; k < ckq.size(); k++) begin
                t = ckq[k];
                for (int p = 0; p < NCOMMIT; p++)
                    if (s.cv[p] && s.ctgt[p] != 0 && t.s[s.ctgt[p]] == s.cid[p]) t.v[s.ctgt[p]] = 1'b1;
                ckq[k] = t;
            end
            if (s.restore) begin
                pos = (int'(s.rndx) - mhead + NCKPT) % NCKPT;
                if (s.req) er = 1'b1;
                if (pos >= ckq.size()) begin
                    er = 1'b1;
                end else begin
                    t = ckq[pos];
                    nv = t.v; ns = t.s;
                    while (ckq.size() > pos + 1) void'(ckq.pop_back());
                    if (s.free) begin
                        if (pos == 0) er = 1'b1;
                        else begin void'(ckq.pop_front()); mhead = (mhead + 1) % NCKPT; end
                    end
                end
            end else begin
                sn.v = nv; sn.s = ns;
                for (int l = 0; l < NDISP; l++) begin
                    if (s.dv[l] && s.drfw[l] && s.dtgt[l] != 0) begin
                        nv[s.dtgt[l]] = 1'b0; ns[s.dtgt[l]] = s.did[l];
                    end
                    if (l == int'(s.lane)) begin sn.v = nv; sn.s = ns; end
                end
                dofree = s.free && ckq.size() > 0;
                if (s.free && !dofree) er = 1'b1;
                doreq = s.req && (ckq.size() < NCKPT || dofree);
                if (s.req && !doreq) er = 1'b1;
                if (dofree) begin void'(ckq.pop_front()); mhead = (mhead + 1) % NCKPT; end
                if (doreq) ckq.push_back(sn);
            end
            mv = nv; ms = ns;
        end
        e.v = mv; e.s = ms; e.full = (ckq.size() == NCKPT);
        e.ndx = 2'((mhead + ckq.size()) % NCKPT); e.err = er;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst;
        bus.disp_v = s.dv; bus.disp_rfw = s.drfw; bus.disp_tgt = s.dtgt; bus.disp_id = s.did;
        bus.ckpt_req = s.req; bus.ckpt_lane = s.lane; bus.ckpt_free = s.free;
        bus.restore = s.restore; bus.restore_ndx = s.rndx;
        bus.commit_v = s.cv; bus.commit_tgt = s.ctgt; bus.commit_id = s.cid;
        model_step(s, e);
        expq.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic dchk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            ncyc++;
            checks += 5;
            if (bus.rf_v !== e.v) begin errors++; $display("FAIL rf_v n=%0d got=%h exp=%h", ncyc, bus.rf_v, e.v); end
            if (bus.rf_source !== e.s) begin errors++; $display("FAIL rf_source n=%0d got=%h exp=%h", ncyc, bus.rf_source, e.s); end
            if (bus.ckpt_full !== e.full) begin errors++; $display("FAIL ckpt_full n=%0d got=%b exp=%b", ncyc, bus.ckpt_full, e.full); end
            if (bus.ckpt_ndx !== e.ndx) begin errors++; $display("FAIL ckpt_ndx n=%0d got=%0d exp=%0d", ncyc, bus.ckpt_ndx, e.ndx); end
            if (bus.ckpt_err !== e.err) begin errors++; $display("FAIL ckpt_err n=%0d got=%b exp=%b", ncyc, bus.ckpt_err, e.err); end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        bus.disp_v = '0; bus.disp_rfw = '0; bus.disp_tgt = '0; bus.disp_id = '0;
        bus.ckpt_req = 1'b0; bus.ckpt_lane = '0; bus.ckpt_free = 1'b0;
        bus.restore = 1'b0; bus.restore_ndx = '0;
        bus.commit_v = '0; bus.commit_tgt = '0; bus.commit_id = '0;

        s = '0; s.rst = 1'b1; step(s);
        // same-target lanes, stale and matching commits
        s = '0; s.dv = 2'b11; s.drfw = 2'b11; s.dtgt[0] = 6'd5; s.did[0] = 5'd3;
        s.dtgt[1] = 6'd5; s.did[1] = 5'd7; step(s); settle();
        dchk("tp1_v5", 64'(bus.rf_v[5]), 64'd0);
        dchk("tp1_src5", 64'(bus.rf_source[5*IDW +: IDW]), 64'd7);
        s = '0; s.cv = 2'b01; s.ctgt[0] = 6'd5; s.cid[0] = 5'd3; step(s); settle();
        dchk("tp1_stale", 64'(bus.rf_v[5]), 64'd0);
        s = '0; s.cv = 2'b10; s.ctgt[1] = 6'd5; s.cid[1] = 5'd7; step(s); settle();
        dchk("tp1_commit", 64'(bus.rf_v[5]), 64'd1);
        // register 0 write is dropped
        s = '0; s.dv = 2'b01; s.drfw = 2'b01; s.dtgt[0] = 6'd0; s.did[0] = 5'd9; step(s); settle();
        dchk("tp2_v0", 64'(bus.rf_v[0]), 64'd1);
        dchk("tp2_src0", 64'(bus.rf_source[0 +: IDW]), 64'd0);
        // checkpoint covers lane0 only, then restore
        dchk("tp3_ndx0", 64'(bus.ckpt_ndx), 64'd0);
        s = '0; s.dv = 2'b11; s.drfw = 2'b11; s.dtgt[0] = 6'd8; s.did[0] = 5'd2;
        s.dtgt[1] = 6'd9; s.did[1] = 5'd4; s.req = 1'b1; s.lane = 1'b0; step(s);
        s = '0; s.restore = 1'b1; s.rndx = 2'd0; step(s); settle();
        dchk("tp3_v8", 64'(bus.rf_v[8]), 64'd0);
        dchk("tp3_v9", 64'(bus.rf_v[9]), 64'd1);
        dchk("tp3_src8", 64'(bus.rf_source[8*IDW +: IDW]), 64'd2);
        dchk("tp3_tail", 64'(bus.ckpt_ndx), 64'd1);
        // commit reaches the snapshot even though a younger dispatch overrides it live
        s = '0; s.cv = 2'b01; s.ctgt[0] = 6'd8; s.cid[0] = 5'd2;
        s.dv = 2'b01; s.drfw = 2'b01; s.dtgt[0] = 6'd8; s.did[0] = 5'd11; step(s); settle();
        dchk("tp4_live_v8", 64'(bus.rf_v[8]), 64'd0);
        s = '0; s.restore = 1'b1; s.rndx = 2'd0; step(s); settle();
        dchk("tp4_v8", 64'(bus.rf_v[8]), 64'd1);
        dchk("tp4_src8", 64'(bus.rf_source[8*IDW +: IDW]), 64'd2);
        // fill, overflow, and req+free while full
        s = '0; s.rst = 1'b1; step(s);
        for (int i = 0; i < 4; i++) begin s = '0; s.req = 1'b1; step(s); end
        settle();
        dchk("tp5_full", 64'(bus.ckpt_full), 64'd1);
        s = '0; s.req = 1'b1; step(s); settle();
        dchk("tp5_err", 64'(bus.ckpt_err), 64'd1);
        dchk("tp5_tail", 64'(bus.ckpt_ndx), 64'd0);
        s = '0; s.req = 1'b1; s.free = 1'b1; step(s); settle();
        dchk("tp5_errpulse", 64'(bus.ckpt_err), 64'd0);
        dchk("tp5_full2", 64'(bus.ckpt_full), 64'd1);
        dchk("tp5_tail2", 64'(bus.ckpt_ndx), 64'd1);
        // reset in a restore cycle
        s = '0; s.dv = 2'b01; s.drfw = 2'b01; s.dtgt[0] = 6'd3; s.did[0] = 5'd5; step(s);
        s = '0; s.rst = 1'b1; s.restore = 1'b1; s.rndx = 2'd2; step(s); settle();
        dchk("tp6_v", bus.rf_v, '1);
        dchk("tp6_full", 64'(bus.ckpt_full), 64'd0);
        dchk("tp6_ndx", 64'(bus.ckpt_ndx), 64'd0);
        s = '0; step(s);

        for (int n = 0; n < 600; n++) begin
            s = '0;
            s.rst = ($urandom_range(0, 249) == 0);
            for (int l = 0; l < NDISP; l++) begin
                s.dv[l] = ($urandom_range(0, 3) != 0);
                s.drfw[l] = ($urandom_range(0, 4) != 0);
                s.dtgt[l] = 6'($urandom_range(0, 15));
                s.did[l] = 5'($urandom);
            end
            s.req = ($urandom_range(0, 3) == 0);
            s.lane = 1'($urandom);
            s.free = ($urandom_range(0, 5) == 0);
            s.restore = ($urandom_range(0, 9) == 0);
            s.rndx = 2'($urandom);
            for (int p = 0; p < NCOMMIT; p++) begin
                s.cv[p] = ($urandom_range(0, 2) != 0);
                s.ctgt[p] = 6'($urandom_range(0, 15));
                s.cid[p] = ($urandom_range(0, 2) != 0) ? ms[s.ctgt[p]] : 5'($urandom);
            end
            step(s);
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
